// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream and writes 33-bit instruction words
// from address 0, holding the core in reset until a frame completes with a good checksum.
module imem_loader #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t             state;
    logic [7:0]         cnt_lo;
    logic [7:0]         xor_acc;
    logic [ADDR_W:0]    word_idx;
    logic [ADDR_W:0]    last_idx;
    logic [2:0]         byte_idx;
    logic [INSTR_W-2:0] word_buf;
    logic [15:0]        count;
    logic [15:0]        count_m1;
    logic               count_ok;
    logic               accept;

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            HDR0, HDR1, DATA, CHK: rx_ready = 1'b1;
            default:               rx_ready = 1'b0;
        endcase
    end

    assign accept   = rx_valid && rx_ready;
    assign count    = {rx_data, cnt_lo};
    assign count_m1 = count - 16'd1;
    assign count_ok = (count != 16'd0) && ({1'b0, count} <= MAX_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_lo     <= '0;
            xor_acc    <= '0;
            word_idx   <= '0;
            last_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= HDR0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                        xor_acc   <= '0;
                        cpu_rst_n <= 1'b0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        cnt_lo  <= rx_data;
                        xor_acc <= xor_acc ^ rx_data;
                        state   <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ rx_data;
                        if (count_ok) begin
                            last_idx <= count_m1[ADDR_W:0];
                            state    <= DATA;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ rx_data;
                        if (byte_idx == 3'd4) begin
                            // Fifth byte contributes only its LSB as instruction bit 32.
                            imem_we    <= 1'b1;
                            imem_waddr <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {rx_data[0], word_buf};
                            byte_idx   <= '0;
                            word_idx   <= word_idx + 1'b1;
                            if (word_idx == last_idx)
                                state <= CHK;
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (rx_data == xor_acc) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                            state     <= DONE;
                        end else begin
                            error     <= 1'b1;
                            cpu_rst_n <= 1'b0;
                            state     <= ERR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and the captured
// memory writes and status outputs are compared with hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [8:0]  imem_waddr;
    logic [32:0] imem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [8:0]  wr_addr [0:2047];
    logic [32:0] wr_data [0:2047];
    int unsigned wr_n = 0;
    logic [7:0]  tb_xor;

    imem_loader #(.ADDR_W(9), .INSTR_W(33)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_n < 2048) begin
            wr_addr[wr_n] = imem_waddr;
            wr_data[wr_n] = imem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tb_xor = 8'h00;
    endtask

    // Presents one byte and waits (bounded) for it to be accepted.
    task automatic send(input logic [7:0] b, input bit gaps, input bit mid_start);
        int unsigned w;
        if (gaps) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 0) break;
                rx_valid = 1'b0;
                tick();
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (rx_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
        if (mid_start) start = 1'b1;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        tb_xor   = tb_xor ^ b;
    endtask

    task automatic send_word(input logic [32:0] wd, input bit gaps, input bit mid_start);
        send(wd[7:0],   gaps, 1'b0);
        send(wd[15:8],  gaps, mid_start);
        send(wd[23:16], gaps, 1'b0);
        send(wd[31:24], gaps, 1'b0);
        send({7'b1010101, wd[32]}, gaps, 1'b0);
    endtask

    logic [32:0] four_words [0:3];
    int unsigned base;

    initial begin
        four_words[0] = 33'h1_DEADBEEF;
        four_words[1] = 33'h0_01234567;
        four_words[2] = 33'h1_FFFFFFFF;
        four_words[3] = 33'h0_00000000;

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tb_xor = 8'h00;
        tick(); tick();
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_we", {63'd0, imem_we}, 64'd0);
        check("rst_waddr", {55'd0, imem_waddr}, 64'd0);
        check("rst_wdata", {31'd0, imem_wdata}, 64'd0);
        check("rst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        rst = 1'b0;
        tick();

        // One-word load; XOR of 01 00 78 56 34 12 01 is 08.
        base = wr_n;
        pulse_start();
        check("w1_rx_ready_hdr0", {63'd0, rx_ready}, 64'd1);
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        send(8'h78, 0, 0); send(8'h56, 0, 0); send(8'h34, 0, 0); send(8'h12, 0, 0);
        send(8'h01, 0, 0);
        check("w1_we", {63'd0, imem_we}, 64'd1);
        check("w1_waddr", {55'd0, imem_waddr}, 64'd0);
        check("w1_wdata", {31'd0, imem_wdata}, 64'h1_12345678);
        check("w1_done_before_chk", {63'd0, done}, 64'd0);
        send(8'h08, 0, 0);
        check("w1_we_after", {63'd0, imem_we}, 64'd0);
        check("w1_done", {63'd0, done}, 64'd1);
        check("w1_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
        check("w1_error", {63'd0, error}, 64'd0);
        check("w1_rx_ready_done", {63'd0, rx_ready}, 64'd0);
        tick();
        check("w1_writes", 64'(wr_n - base), 64'd1);

        // Full 512-word load, word i = i; checksum works out to 02.
        base = wr_n;
        pulse_start();
        check("full_cpu_rst_n_held", {63'd0, cpu_rst_n}, 64'd0);
        check("full_done_cleared", {63'd0, done}, 64'd0);
        send(8'h00, 0, 0); send(8'h02, 0, 0);
        for (int i = 0; i < 512; i++) send_word(33'(i), 0, 0);
        check("full_xor", {56'd0, tb_xor}, 64'h02);
        send(8'h02, 0, 0);
        check("full_done", {63'd0, done}, 64'd1);
        check("full_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
        tick();
        check("full_writes", 64'(wr_n - base), 64'd512);
        for (int i = 0; i < 512; i++) begin
            check("full_addr", {55'd0, wr_addr[base + i]}, 64'(i));
            check("full_data", {31'd0, wr_data[base + i]}, 64'(i));
        end

        // Bad counts: 0 and 513.
        base = wr_n;
        pulse_start();
        send(8'h00, 0, 0); send(8'h00, 0, 0);
        check("cnt0_error", {63'd0, error}, 64'd1);
        check("cnt0_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("cnt0_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        check("cnt0_done", {63'd0, done}, 64'd0);
        pulse_start();
        check("cnt513_error_cleared", {63'd0, error}, 64'd0);
        send(8'h01, 0, 0); send(8'h02, 0, 0);
        check("cnt513_error", {63'd0, error}, 64'd1);
        check("cnt513_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("cnt513_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        tick(); tick();
        check("badcnt_writes", 64'(wr_n - base), 64'd0);

        // Checksum mismatch, then recovery with a good frame.
        base = wr_n;
        pulse_start();
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        send(8'h78, 0, 0); send(8'h56, 0, 0); send(8'h34, 0, 0); send(8'h12, 0, 0);
        send(8'h01, 0, 0);
        send(8'h00, 0, 0);
        check("bad_chk_error", {63'd0, error}, 64'd1);
        check("bad_chk_done", {63'd0, done}, 64'd0);
        check("bad_chk_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        tick();
        check("bad_chk_writes", 64'(wr_n - base), 64'd1);
        check("bad_chk_addr", {55'd0, wr_addr[base]}, 64'd0);
        check("bad_chk_data", {31'd0, wr_data[base]}, 64'h1_12345678);
        pulse_start();
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        send(8'h78, 0, 0); send(8'h56, 0, 0); send(8'h34, 0, 0); send(8'h12, 0, 0);
        send(8'h01, 0, 0);
        send(8'h08, 0, 0);
        check("recover_done", {63'd0, done}, 64'd1);
        check("recover_error", {63'd0, error}, 64'd0);
        check("recover_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);

        // Four words, gap-free then with random rx_valid gaps and stray start pulses.
        for (int pass = 0; pass < 2; pass++) begin
            base = wr_n;
            pulse_start();
            send(8'h04, pass == 1, 0); send(8'h00, pass == 1, pass == 1);
            for (int i = 0; i < 4; i++) send_word(four_words[i], pass == 1, pass == 1);
            send(tb_xor, pass == 1, 0);
            check("w4_done", {63'd0, done}, 64'd1);
            check("w4_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
            tick();
            check("w4_writes", 64'(wr_n - base), 64'd4);
            for (int i = 0; i < 4; i++) begin
                check("w4_addr", {55'd0, wr_addr[base + i]}, 64'(i));
                check("w4_data", {31'd0, wr_data[base + i]}, {31'd0, four_words[i]});
            end
        end

        // Reset after 7 data bytes of a two-word frame.
        pulse_start();
        send(8'h02, 0, 0); send(8'h00, 0, 0);
        send_word(33'h0_CAFEF00D, 0, 0);
        send(8'hAA, 0, 0); send(8'hBB, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("mid_rst_we", {63'd0, imem_we}, 64'd0);
        check("mid_rst_waddr", {55'd0, imem_waddr}, 64'd0);
        check("mid_rst_wdata", {31'd0, imem_wdata}, 64'd0);
        check("mid_rst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_error", {63'd0, error}, 64'd0);
        base = wr_n;
        pulse_start();
        send(8'h02, 0, 0); send(8'h00, 0, 0);
        send_word(33'h1_00000001, 0, 0);
        send_word(33'h0_80000002, 0, 0);
        send(tb_xor, 0, 0);
        check("post_rst_done", {63'd0, done}, 64'd1);
        tick();
        check("post_rst_writes", 64'(wr_n - base), 64'd2);
        check("post_rst_addr0", {55'd0, wr_addr[base]}, 64'd0);
        check("post_rst_data0", {31'd0, wr_data[base]}, 64'h1_00000001);
        check("post_rst_addr1", {55'd0, wr_addr[base + 1]}, 64'd1);
        check("post_rst_data1", {31'd0, wr_data[base + 1]}, 64'h0_80000002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
